// File: rtl/jtag_mem_arbiter.sv
// Arbitrates a single-port word memory between the CPU data port and the TCK-domain debug bridge.
// Define JTAG_ARB_STARVE_EN to bound how long a pending debug request can lose to the CPU.
module jtag_mem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MEM_AW   = 14,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DBG_REQ_TGL,
    input  logic              DBG_WE,
    input  logic [31:0]       DBG_ADDR,
    input  logic [DATA_W-1:0] DBG_WDATA,
    output logic              DBG_ACK_TGL,
    output logic [DATA_W-1:0] DBG_RDATA,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [3:0]        CPU_BE,
    input  logic [31:0]       CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_GNT,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [3:0]        MEM_BE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ISSUE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              reqMeta_q, reqSync_q;
    logic              reqSeen_q, reqSeen_d;
    logic              dbgWe_q, dbgWe_d;
    logic [MEM_AW-1:0] dbgAddr_q, dbgAddr_d;
    logic [DATA_W-1:0] dbgWdata_q, dbgWdata_d;
    logic              ackTgl_q, ackTgl_d;
    logic [DATA_W-1:0] dbgRdata_q, dbgRdata_d;
    logic              cpuRvalid_q;
    logic              forceGnt;
    logic              dbgIssue;

    // Address bits outside the word index are intentionally ignored (silent wrap).
    logic unusedAddrBits;
    assign unusedAddrBits = ^{DBG_ADDR[31:MEM_AW+2], DBG_ADDR[1:0],
                              CPU_ADDR[31:MEM_AW+2], CPU_ADDR[1:0]};

`ifdef JTAG_ARB_STARVE_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

    assign forceGnt = (waitCnt_q == CNT_W'(MAX_WAIT));

    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_q == PEND) begin
            if (state_d == ISSUE) begin
                waitCnt_d = '0;
            end else if (CPU_REQ) begin
                waitCnt_d = waitCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`else
    localparam int unusedMaxWait = MAX_WAIT;

    assign forceGnt = 1'b0;
`endif

    assign CPU_GNT     = CPU_REQ && (state_q != ISSUE);
    assign CPU_RVALID  = cpuRvalid_q;
    assign CPU_RDATA   = MEM_RDATA;
    assign DBG_ACK_TGL = ackTgl_q;
    assign DBG_RDATA   = dbgRdata_q;

    // req_seen only advances on acceptance, so toggles arriving mid-access are re-detected in IDLE.
    always_comb begin
        state_d    = state_q;
        reqSeen_d  = reqSeen_q;
        dbgWe_d    = dbgWe_q;
        dbgAddr_d  = dbgAddr_q;
        dbgWdata_d = dbgWdata_q;
        ackTgl_d   = ackTgl_q;
        dbgRdata_d = dbgRdata_q;
        dbgIssue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqSync_q != reqSeen_q) begin
                    reqSeen_d  = reqSync_q;
                    dbgWe_d    = DBG_WE;
                    dbgAddr_d  = DBG_ADDR[MEM_AW+1:2];
                    dbgWdata_d = DBG_WDATA;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (!CPU_REQ || forceGnt) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dbgIssue = 1'b1;
                if (dbgWe_q) begin
                    ackTgl_d = ~ackTgl_q;
                    state_d  = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                dbgRdata_d = MEM_RDATA;
                ackTgl_d   = ~ackTgl_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // At most one master drives the memory; everything is zero when nobody does.
    always_comb begin
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_BE    = 4'h0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        if (dbgIssue) begin
            MEM_EN    = 1'b1;
            MEM_WE    = dbgWe_q;
            MEM_BE    = 4'hF;
            MEM_ADDR  = dbgAddr_q;
            MEM_WDATA = dbgWdata_q;
        end else if (CPU_GNT) begin
            MEM_EN    = 1'b1;
            MEM_WE    = CPU_WE;
            MEM_BE    = CPU_BE;
            MEM_ADDR  = CPU_ADDR[MEM_AW+1:2];
            MEM_WDATA = CPU_WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            reqMeta_q   <= 1'b0;
            reqSync_q   <= 1'b0;
            reqSeen_q   <= 1'b0;
            dbgWe_q     <= 1'b0;
            dbgAddr_q   <= '0;
            dbgWdata_q  <= '0;
            ackTgl_q    <= 1'b0;
            dbgRdata_q  <= '0;
            cpuRvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            reqMeta_q   <= DBG_REQ_TGL;
            reqSync_q   <= reqMeta_q;
            reqSeen_q   <= reqSeen_d;
            dbgWe_q     <= dbgWe_d;
            dbgAddr_q   <= dbgAddr_d;
            dbgWdata_q  <= dbgWdata_d;
            ackTgl_q    <= ackTgl_d;
            dbgRdata_q  <= dbgRdata_d;
            cpuRvalid_q <= CPU_GNT && !CPU_WE;
        end
    end

endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// Self-checking bench for jtag_mem_arbiter: directed scenarios plus randomized CPU/debug traffic
// checked against a word-memory reference model and an ordered queue of outstanding debug requests.
module tb_jtag_mem_arbiter;

    localparam int DATA_W   = 32;
    localparam int MEM_AW   = 14;
    localparam int MAX_WAIT = 15;
    localparam int DEPTH    = 1 << MEM_AW;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              DBG_REQ_TGL;
    logic              DBG_WE;
    logic [31:0]       DBG_ADDR;
    logic [DATA_W-1:0] DBG_WDATA;
    logic              DBG_ACK_TGL;
    logic [DATA_W-1:0] DBG_RDATA;
    logic              CPU_REQ;
    logic              CPU_WE;
    logic [3:0]        CPU_BE;
    logic [31:0]       CPU_ADDR;
    logic [DATA_W-1:0] CPU_WDATA;
    logic              CPU_GNT;
    logic              CPU_RVALID;
    logic [DATA_W-1:0] CPU_RDATA;
    logic              MEM_EN;
    logic              MEM_WE;
    logic [3:0]        MEM_BE;
    logic [MEM_AW-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;

    always #5 CLK = ~CLK;

    jtag_mem_arbiter #(
        .DATA_W  (DATA_W),
        .MEM_AW  (MEM_AW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DBG_REQ_TGL(DBG_REQ_TGL),
        .DBG_WE     (DBG_WE),
        .DBG_ADDR   (DBG_ADDR),
        .DBG_WDATA  (DBG_WDATA),
        .DBG_ACK_TGL(DBG_ACK_TGL),
        .DBG_RDATA  (DBG_RDATA),
        .CPU_REQ    (CPU_REQ),
        .CPU_WE     (CPU_WE),
        .CPU_BE     (CPU_BE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .CPU_GNT    (CPU_GNT),
        .CPU_RVALID (CPU_RVALID),
        .CPU_RDATA  (CPU_RDATA),
        .MEM_EN     (MEM_EN),
        .MEM_WE     (MEM_WE),
        .MEM_BE     (MEM_BE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA)
    );

    // Memory macro: byte-enabled writes, one-cycle registered reads.
    logic [31:0] macroMem [DEPTH] = '{default: '0};
    logic [31:0] macroRdata = '0;
    assign MEM_RDATA = macroRdata;

    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) begin
                for (int b = 0; b < 4; b++) begin
                    if (MEM_BE[b]) macroMem[MEM_ADDR][8*b +: 8] <= MEM_WDATA[8*b +: 8];
                end
            end else begin
                macroRdata <= macroMem[MEM_ADDR];
            end
        end
    end

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [31:0]       wdata;
    } DbgReq;

    typedef struct packed {
        logic        we;
        logic [31:0] rdata;
    } DbgAck;

    logic [31:0] refMem [DEPTH] = '{default: '0};
    DbgReq       dbgQ[$];
    DbgAck       ackQ[$];
    DbgReq       curReq;
    DbgAck       curAck;
    int          checks = 0;
    int          errors = 0;
    int          ackCount = 0;
    logic        lastAck = 1'b0;
    logic        expRvalid = 1'b0;
    logic [31:0] expCpuRdata = '0;
    logic        dbgDone;
    int          startCount;
    int          waitN;
    int          rStart;
    int          rN;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [MEM_AW-1:0] wordOf(input logic [31:0] a);
        return MEM_AW'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        DbgReq r;
        DBG_WE      = we;
        DBG_ADDR    = addr;
        DBG_WDATA   = wdata;
        DBG_REQ_TGL = ~DBG_REQ_TGL;
        r.we    = we;
        r.addr  = wordOf(addr);
        r.wdata = wdata;
        dbgQ.push_back(r);
    endtask

    task automatic waitAck(input string tag, input int expLat, input int already);
        logic startAck;
        int   n;
        startAck = DBG_ACK_TGL;
        n = already;
        while (DBG_ACK_TGL === startAck && n < 200) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(n), 64'(expLat));
        @(negedge CLK);
        #1;
    endtask

    // Bus and acknowledge monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RESET) begin
            lastAck   = DBG_ACK_TGL;
            expRvalid = 1'b0;
        end else begin
            checkOutput("cpu_rvalid", 64'(CPU_RVALID), 64'(expRvalid));
            if (expRvalid) checkOutput("cpu_rdata", 64'(CPU_RDATA), 64'(expCpuRdata));
            expRvalid = 1'b0;
            if (!MEM_EN) checkOutput("mem_idle_zero", 64'({MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}), 64'(0));
            if (MEM_EN && !CPU_GNT) begin
                checkOutput("dbg_expected", 64'(dbgQ.size() != 0), 64'(1));
                if (dbgQ.size() != 0) begin
                    curReq = dbgQ.pop_front();
                    checkOutput("dbg_mem", 64'({MEM_WE, MEM_BE, MEM_ADDR}), 64'({curReq.we, 4'hF, curReq.addr}));
                    curAck.we = curReq.we;
                    curAck.rdata = refMem[curReq.addr];
                    if (curReq.we) begin
                        checkOutput("dbg_wdata", 64'(MEM_WDATA), 64'(curReq.wdata));
                        refMem[curReq.addr] = curReq.wdata;
                    end
                    ackQ.push_back(curAck);
                end
            end else begin
                checkOutput("cpu_gnt", 64'(CPU_GNT), 64'(CPU_REQ));
                if (CPU_GNT) begin
                    checkOutput("cpu_mem_ctl", 64'({MEM_EN, MEM_WE, MEM_ADDR}), 64'({1'b1, CPU_WE, wordOf(CPU_ADDR)}));
                    if (CPU_WE) begin
                        checkOutput("cpu_mem_wr", 64'({MEM_BE, MEM_WDATA}), 64'({CPU_BE, CPU_WDATA}));
                        refMem[wordOf(CPU_ADDR)] = mergeBytes(refMem[wordOf(CPU_ADDR)], CPU_WDATA, CPU_BE);
                    end else begin
                        expRvalid   = 1'b1;
                        expCpuRdata = refMem[wordOf(CPU_ADDR)];
                    end
                end
            end
            if (DBG_ACK_TGL !== lastAck) begin
                lastAck = DBG_ACK_TGL;
                ackCount++;
                checkOutput("ack_expected", 64'(ackQ.size() != 0), 64'(1));
                if (ackQ.size() != 0) begin
                    curAck = ackQ.pop_front();
                    if (!curAck.we) checkOutput("dbg_rdata", 64'(DBG_RDATA), 64'(curAck.rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET       = 1'b1;
        DBG_REQ_TGL = 1'b0;
        DBG_WE      = 1'b0;
        DBG_ADDR    = '0;
        DBG_WDATA   = '0;
        CPU_REQ     = 1'b0;
        CPU_WE      = 1'b0;
        CPU_BE      = 4'h0;
        CPU_ADDR    = '0;
        CPU_WDATA   = '0;
        dbgDone     = 1'b0;
        repeat (3) tick();
        checkOutput("rst_ack", 64'(DBG_ACK_TGL), 64'(0));
        checkOutput("rst_rdata", 64'(DBG_RDATA), 64'(0));
        checkOutput("rst_rvalid", 64'(CPU_RVALID), 64'(0));
        checkOutput("rst_mem_en", 64'(MEM_EN), 64'(0));
        RESET = 1'b0;
        tick();

        // Debug write with CPU idle, then read it back.
        applyStimulus(1'b1, 32'h40, 32'hDEADBEEF);
        repeat (4) tick();
        @(negedge CLK);
        checkOutput("wr_mem_bus", 64'({MEM_EN, MEM_WE, MEM_BE, MEM_ADDR, MEM_WDATA}),
                    64'({1'b1, 1'b1, 4'hF, 14'h0010, 32'hDEADBEEF}));
        waitAck("wr_latency", 5, 4);
        applyStimulus(1'b0, 32'h40, 32'h0);
        waitAck("rd_latency", 6, 0);
        checkOutput("rd_data", 64'(DBG_RDATA), 64'(32'hDEADBEEF));

        // CPU read collides with the debug ISSUE cycle; address upper bits wrap.
        applyStimulus(1'b1, 32'h0001_0084, 32'h12345678);
        repeat (4) tick();
        CPU_REQ  = 1'b1;
        CPU_WE   = 1'b0;
        CPU_ADDR = 32'h84;
        @(negedge CLK);
        checkOutput("coll_gnt_issue", 64'(CPU_GNT), 64'(0));
        tick();
        @(negedge CLK);
        checkOutput("coll_gnt_next", 64'(CPU_GNT), 64'(1));
        tick();
        CPU_REQ = 1'b0;
        @(negedge CLK);
        checkOutput("coll_rvalid", 64'(CPU_RVALID), 64'(1));
        checkOutput("coll_rdata", 64'(CPU_RDATA), 64'(32'h12345678));
        tick();

        // Second toggle lands while the first access is in ISSUE.
        startCount = ackCount;
        applyStimulus(1'b0, 32'h40, 32'h0);
        repeat (4) tick();
        applyStimulus(1'b1, 32'h88, 32'hCAFEF00D);
        waitN = 0;
        while (ackCount - startCount < 2 && waitN < 40) begin
            tick();
            waitN++;
        end
        checkOutput("b2b_acks", 64'(ackCount - startCount), 64'(2));
        tick();

        // CPU holds the port continuously while a debug read is pending.
        CPU_REQ  = 1'b1;
        CPU_WE   = 1'b0;
        CPU_ADDR = 32'h88;
        startCount = ackCount;
        applyStimulus(1'b0, 32'h40, 32'h0);
`ifdef JTAG_ARB_STARVE_EN
        waitN = 0;
        while (ackCount == startCount && waitN < MAX_WAIT + 12) begin
            tick();
            waitN++;
        end
        checkOutput("starve_forced", 64'(ackCount - startCount), 64'(1));
`else
        repeat (60) tick();
        checkOutput("starve_hold", 64'(ackCount - startCount), 64'(0));
`endif
        CPU_REQ = 1'b0;
        waitN = 0;
        while (ackCount == startCount && waitN < 50) begin
            tick();
            waitN++;
        end
        checkOutput("starve_done", 64'(ackCount - startCount), 64'(1));
        tick();

        // Reset while a debug read sits in RESP: no ack, outputs cleared, next request normal.
        applyStimulus(1'b0, 32'h88, 32'h0);
        repeat (5) tick();
        RESET       = 1'b1;
        DBG_REQ_TGL = 1'b0;
        dbgQ.delete();
        ackQ.delete();
        repeat (2) tick();
        checkOutput("rst_resp_ack", 64'(DBG_ACK_TGL), 64'(0));
        checkOutput("rst_resp_rdata", 64'(DBG_RDATA), 64'(0));
        checkOutput("rst_resp_rvalid", 64'(CPU_RVALID), 64'(0));
        RESET = 1'b0;
        tick();
        applyStimulus(1'b0, 32'h88, 32'h0);
        waitAck("post_rst_latency", 6, 0);
        checkOutput("post_rst_data", 64'(DBG_RDATA), 64'(32'hCAFEF00D));

        // Randomized concurrent CPU and debug traffic.
        fork
            begin
                while (!dbgDone) begin
                    CPU_REQ   = ($urandom_range(0, 3) != 0);
                    CPU_WE    = 1'($urandom_range(0, 1));
                    CPU_BE    = 4'($urandom);
                    CPU_ADDR  = {16'($urandom), 10'h0, 4'($urandom), 2'($urandom)};
                    CPU_WDATA = $urandom;
                    tick();
                end
                CPU_REQ = 1'b0;
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    repeat ($urandom_range(0, 5)) tick();
                    rStart = ackCount;
                    applyStimulus(1'($urandom_range(0, 1)),
                                  {16'($urandom), 10'h0, 4'($urandom), 2'($urandom)}, $urandom);
                    rN = 0;
                    while (ackCount == rStart && rN < 400) begin
                        tick();
                        rN++;
                    end
                    checkOutput("rand_ack", 64'(ackCount - rStart), 64'(1));
                end
                dbgDone = 1'b1;
            end
        join
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
